// File: rtl/alu_rr_sched.sv
// alu_rr_sched
//
// Purpose:
//   Two requesters share one flag-producing ALU. A round-robin scheduler
//   accepts one request at a time, registers its operands and executes it in
//   one cycle. It then presents the result and the {z,c,n,v} flags on a
//   valid/ready response channel. The block also keeps a persistent copy of
//   the last op's flags and a wrapping count of delivered responses.
//
// Parameters:
//   Width    - operand/result width in bits (>= 2)
//   CntWidth - width of the completed-operation counter
//
// Ports:
//   clk, rst             - rising-edge clock, synchronous active-high reset
//   req_valid[1:0]       - requester i has an op pending
//   req_ready[1:0]       - request i accepted this cycle (one-hot or zero)
//   req_a0/b0/op0        - operands and opcode of requester 0
//   req_a1/b1/op1        - operands and opcode of requester 1
//   rsp_valid, rsp_ready - response handshake
//   rsp_id               - requester index of the response
//   rsp_result           - ALU result
//   rsp_flags            - {z,c,n,v} of this response
//   flags                - {z,c,n,v} of the last completed op (persistent)
//   busy                 - scheduler is not idle
//   op_count             - responses delivered, wraps modulo 2^CntWidth
//
// Opcodes: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 ~B,
//          111 zero. c/v are meaningful only for add/sub and are 0 otherwise.

module alu_rr_sched #(
  parameter int Width    = 8,
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [Width-1:0]    req_a0,
  input  logic [Width-1:0]    req_b0,
  input  logic [2:0]          req_op0,
  input  logic [Width-1:0]    req_a1,
  input  logic [Width-1:0]    req_b1,
  input  logic [2:0]          req_op1,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [Width-1:0]    rsp_result,
  output logic [3:0]          rsp_flags,
  output logic [3:0]          flags,
  output logic                busy,
  output logic [CntWidth-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [Width-1:0]      a_q, a_d;
  logic [Width-1:0]      b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic                  id_q, id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [Width-1:0]      rsp_result_q, rsp_result_d;
  logic [3:0]            rsp_flags_q, rsp_flags_d;
  logic [3:0]            flags_q, flags_d;
  logic [CntWidth-1:0]   op_count_q, op_count_d;

  // ---------------------------------------------------------------------------
  // ALU on the registered operands
  // ---------------------------------------------------------------------------
  logic [Width:0]   sum_ext;
  logic [Width:0]   diff_ext;
  logic [Width-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    // The extra top bit carries the add carry-out or the subtract borrow.
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} - {1'b0, b_q};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op_q)
      3'b000: begin
        alu_res = sum_ext[Width-1:0];
        alu_c   = sum_ext[Width];
        // Overflow: like-signed operands produce a result of the other sign.
        alu_v   = (a_q[Width-1] == b_q[Width-1]) &&
                  (alu_res[Width-1] != a_q[Width-1]);
      end
      3'b001: begin
        alu_res = diff_ext[Width-1:0];
        alu_c   = diff_ext[Width];
        // Overflow: unlike-signed operands and the result sign differs from A.
        alu_v   = (a_q[Width-1] != b_q[Width-1]) &&
                  (alu_res[Width-1] != a_q[Width-1]);
      end
      3'b010:  alu_res = a_q & b_q;
      3'b011:  alu_res = a_q | b_q;
      3'b100:  alu_res = a_q ^ b_q;
      3'b101:  alu_res = ~a_q;
      3'b110:  alu_res = ~b_q;
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = {(alu_res == '0), alu_c, alu_res[Width-1], alu_v};

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic grant_valid;
  logic grant_id;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req_valid == 2'b11) begin
      // On a tie the requester not served last time wins.
      grant_valid = 1'b1;
      grant_id    = ~last_grant_q;
    end else if (req_valid[0]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req_valid[1]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  assign req_ready = (state_q == IDLE && grant_valid) ?
                     (grant_id ? 2'b10 : 2'b01) : 2'b00;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    flags_d      = flags_q;
    op_count_d   = op_count_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          a_d          = grant_id ? req_a1  : req_a0;
          b_d          = grant_id ? req_b1  : req_b0;
          op_d         = grant_id ? req_op1 : req_op0;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_res;
        rsp_flags_d  = alu_flags;
        flags_d      = alu_flags;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CntWidth'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      // NOTE: the operand registers are reset too; they are few and this keeps
      // simulation free of X in the ALU path before the first grant.
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      flags_q      <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      flags_q      <= flags_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign flags      = flags_q;
  assign op_count   = op_count_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched
//
// Scoreboard bench for alu_rr_sched (Width=8, CntWidth=2 so the counter wrap
// is reachable). Stimulus pushes hand-computed responses into exp_q; a monitor
// pops and compares on every response handshake. Inputs are driven on the
// falling edge and outputs are sampled shortly after it.

module tb_alu_rr_sched;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [W-1:0]  req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [2:0]    req_op0 = '0, req_op1 = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_id;
  logic [W-1:0]  rsp_result;
  logic [3:0]    rsp_flags;
  logic [3:0]    flags;
  logic          busy;
  logic [CW-1:0] op_count;

  alu_rr_sched #(.Width(W), .CntWidth(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_op0    (req_op0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_op1    (req_op1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .flags      (flags),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic         id;
    logic [W-1:0] result;
    logic [3:0]   flags;   // {z,c,n,v}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic id, input logic [W-1:0] r,
                              input logic [3:0] f);
    exp_t e;
    e.id = id; e.result = r; e.flags = f;
    return e;
  endfunction

  // Monitor: compare every delivered response against the next expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    #2;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id",     {31'b0, rsp_id},    {31'b0, mon_e.id});
        check("rsp_result", {24'b0, rsp_result}, {24'b0, mon_e.result});
        check("rsp_flags",  {28'b0, rsp_flags},  {28'b0, mon_e.flags});
        check("flags_reg",  {28'b0, flags},      {28'b0, mon_e.flags});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one request, wait (bounded) for its accept, then drop its valid.
  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input string tag);
    @(negedge clk);
    req_valid[id] = 1'b1;
    if (id == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
    else         begin req_a1 = a; req_b1 = b; req_op1 = op; end
    #1;
    for (int i = 0; i < 20 && !req_ready[id]; i++) begin
      @(negedge clk); #1;
    end
    check({tag, "_accept"}, {31'b0, req_ready[id]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    check({tag, "_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int acc_cyc[4];
  int n_acc;
  int viol;
  logic saw_valid;

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    #1;
    check("rst_ready",   {30'b0, req_ready}, 32'd0);
    check("rst_rsp",     {18'b0, rsp_valid, rsp_id, rsp_result, rsp_flags}, 32'd0);
    check("rst_flags",   {28'b0, flags}, 32'd0);
    check("rst_count",   {30'b0, op_count}, 32'd0);
    check("rst_busy",    {31'b0, busy}, 32'd0);

    // ---------------- test 1: FF+01, latency ----------------
    rsp_ready = 1'b1;
    exp_q.push_back(mk(1'b0, 8'h00, 4'b1100));
    @(negedge clk);
    req_valid = 2'b01; req_a0 = 8'hFF; req_b0 = 8'h01; req_op0 = 3'b000;
    #1;
    check("t1_ready", {30'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("t1_exec_busy_nvalid", {30'b0, busy, rsp_valid}, 32'b10);
    @(negedge clk); #1;
    check("t1_rsp_valid_t2", {31'b0, rsp_valid}, 32'd1);
    @(negedge clk); #1;
    check("t1_count", {30'b0, op_count}, 32'd1);
    check("t1_hold",  {19'b0, busy, rsp_valid, rsp_result, flags}, {19'b0, 2'b00, 8'h00, 4'b1100});

    // ---------------- test 2: subtraction via requester 1 ----------------
    exp_q.push_back(mk(1'b1, 8'h80, 4'b0111));
    issue(1, 8'h7F, 8'hFF, 3'b001, "t2a");
    wait_done("t2a");
    exp_q.push_back(mk(1'b1, 8'h7F, 4'b0001));
    issue(1, 8'h80, 8'h01, 3'b001, "t2b");
    wait_done("t2b");
    check("t2_count", {30'b0, op_count}, 32'd3);

    // ---------------- test 3: fairness with both continuously valid ----------------
    do_reset();
    exp_q.push_back(mk(1'b0, 8'h30, 4'b0000));
    exp_q.push_back(mk(1'b1, 8'h00, 4'b1000));
    exp_q.push_back(mk(1'b0, 8'h30, 4'b0000));
    exp_q.push_back(mk(1'b1, 8'h00, 4'b1000));
    @(negedge clk);
    req_a0 = 8'hF0; req_b0 = 8'h3C; req_op0 = 3'b010;
    req_a1 = 8'h0F; req_b1 = 8'hF0; req_op1 = 3'b010;
    req_valid = 2'b11;
    n_acc = 0;
    viol  = 0;
    for (int i = 0; i < 40 && n_acc < 4; i++) begin
      #1;
      if (req_ready == 2'b11) viol++;
      if (req_ready != 2'b00) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    check("t3_accepts", n_acc, 32'd4);
    check("t3_ready_onehot", viol, 32'd0);
    for (int k = 0; k < 3; k++)
      check($sformatf("t3_gap%0d", k), acc_cyc[k+1] - acc_cyc[k], 32'd3);
    wait_done("t3");
    check("t3_count_wrap", {30'b0, op_count}, 32'd0);

    // ---------------- test 4: backpressure ----------------
    rsp_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 8'h46, 4'b0000));
    exp_q.push_back(mk(1'b0, 8'h02, 4'b0000));
    issue(0, 8'h12, 8'h34, 3'b000, "t4a");
    req_valid[0] = 1'b1; req_a0 = 8'h01; req_b0 = 8'h01; req_op0 = 3'b000;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      // {rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready, busy}
      check($sformatf("t4_hold%0d", k),
            {15'b0, rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready, busy},
            {15'b0, 1'b1, 1'b0, 8'h46, 4'b0000, 2'b00, 1'b1});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("t4_ready_in_resp", {30'b0, req_ready}, 32'd0);
    @(negedge clk); #1;
    check("t4_regrant", {29'b0, req_ready, busy}, 32'b010);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    wait_done("t4b");
    check("t4_count", {30'b0, op_count}, 32'd2);

    // ---------------- test 5: reset during EXEC ----------------
    issue(0, 8'h01, 8'h02, 3'b000, "t5a");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_flags", {28'b0, flags}, 32'd0);
    check("t5_count", {30'b0, op_count}, 32'd0);
    check("t5_idle",  {30'b0, busy, rsp_valid}, 32'd0);
    saw_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      saw_valid = saw_valid | rsp_valid;
    end
    check("t5_no_rsp", {31'b0, saw_valid}, 32'd0);
    exp_q.push_back(mk(1'b0, 8'h03, 4'b0000));
    exp_q.push_back(mk(1'b1, 8'h00, 4'b1101));
    @(negedge clk);
    req_a0 = 8'h01; req_b0 = 8'h02; req_op0 = 3'b000;
    req_a1 = 8'h80; req_b1 = 8'h80; req_op1 = 3'b000;
    req_valid = 2'b11;
    #1;
    check("t5_tie_ready", {30'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    for (int i = 0; i < 20 && !req_ready[1]; i++) begin
      @(negedge clk); #1;
    end
    check("t5b_accept", {31'b0, req_ready[1]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    wait_done("t5b");
    check("t5_count_after", {30'b0, op_count}, 32'd2);

    // ---------------- test 6: unary/zero ops and counter wrap ----------------
    do_reset();
    exp_q.push_back(mk(1'b0, 8'hF0, 4'b0010));
    issue(0, 8'h0F, 8'hF0, 3'b101, "t6a");
    wait_done("t6a");
    exp_q.push_back(mk(1'b1, 8'h0F, 4'b0000));
    issue(1, 8'h0F, 8'hF0, 3'b110, "t6b");
    wait_done("t6b");
    exp_q.push_back(mk(1'b0, 8'h00, 4'b1000));
    issue(0, 8'h0F, 8'hF0, 3'b111, "t6c");
    wait_done("t6c");
    check("t6_flags_reg", {28'b0, flags}, 32'b1000);
    check("t6_count3", {30'b0, op_count}, 32'd3);
    exp_q.push_back(mk(1'b1, 8'hFF, 4'b0010));
    issue(1, 8'h0F, 8'hF0, 3'b011, "t6d");
    wait_done("t6d");
    check("t6_count_wrap", {30'b0, op_count}, 32'd0);

    repeat (2) @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Shares one parameterised flag-producing ALU between two requesters.
- Each requester presents an operand pair and a 3-bit opcode over a valid/ready handshake.
- A round-robin scheduler grants one request at a time, registers the operands and executes the operation. It returns result plus z/c/n/v flags over a valid/ready response channel.
- Also keeps a persistent flag register and a completed-operation counter for the surrounding datapath.

Parameters:
- Width, 8, operand/result width in bits (>=2).
- CntWidth, 16, width of completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  2  bit i = requester i has an op pending
- req_ready  output  2  bit i = request i accepted this cycle (one-hot or zero)
- req_a0  input  Width  operand A, requester 0
- req_b0  input  Width  operand B, requester 0
- req_op0  input  3  opcode, requester 0
- req_a1  input  Width  operand A, requester 1
- req_b1  input  Width  operand B, requester 1
- req_op1  input  3  opcode, requester 1
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester index of the response
- rsp_result  output  Width  ALU result
- rsp_flags  output  4  {z,c,n,v} of this response
- flags  output  4  {z,c,n,v} of last completed op (persistent)
- busy  output  1  high when state != IDLE
- op_count  output  CntWidth  number of responses delivered, wraps modulo 2^CntWidth

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_flags=0; flags=0; op_count=0; busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- Opcodes:
  - 000: A+B; c=carry out of bit Width-1; v=signed add overflow.
  - 001: A-B; c=1 iff A<B unsigned (borrow); v=signed sub overflow.
  - 010: A&B. 011: A|B. 100: A^B. 101: ~A. 110: ~B. 111: result 0.
  - For 010-111, c=v=0.
  - For all ops, z=(result==0) and n=result[Width-1].
- FSM states are IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and may be high only in IDLE.
  - Only one valid request: grant it.
  - Both valid: grant the index != last_grant.
  - On grant: capture A, B, op and id into internal registers; last_grant<=id; go to EXEC.
  - No request: stay in IDLE; last_grant is unchanged.
- EXEC (one cycle):
  - ALU evaluates the registered operands.
  - rsp_result, rsp_flags, rsp_id and flags are loaded.
  - rsp_valid<=1; go to RESP.
- RESP:
  - rsp_* stay stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid<=0; op_count<=op_count+1 (wraps to 0); go to IDLE.
- Latency and throughput:
  - Request handshake in cycle T gives rsp_valid high from cycle T+2.
  - With rsp_ready tied high, throughput is one op per 3 cycles.
- Response holding:
  - flags and rsp_flags update only in EXEC.
  - rsp_result and flags hold their last values after the response is consumed.
- Ungranted requesters must hold valid and payload. The scheduler does not sample an ungranted payload.
- A request raised while busy is not accepted until the scheduler returns to IDLE. There is no queuing.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Reset asserted in any state:
  - The in-flight op is discarded with no response.
  - op_count is not incremented.
  - All state returns to reset values on the next edge.
- Width arithmetic uses a Width+1-bit intermediate for add/sub. Result is the low Width bits.

Test Plan:
1. Width=8, reset, then req0 issues op=000, A=0xFF, B=0x01. Required: req_ready0 high in the accept cycle; rsp_valid 2 cycles later; rsp_result=0x00, rsp_flags={z1,c1,n0,v0}, rsp_id=0; op_count=1 after rsp_ready.
2. req1 issues op=001, A=0x7F, B=0xFF. Required: result=0x80, flags={z0,c1,n1,v1}, rsp_id=1. Then op=001, A=0x80, B=0x01: result=0x7F, flags={0,0,0,1}.
3. Both requesters continuously valid after reset with op=010, 4 responses, rsp_ready=1. Required: rsp_id sequence 0,1,0,1; req_ready never 2'b11; one accept every 3 cycles.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP while req0 is valid. Required: rsp_* stable; req_ready=0 throughout; busy=1; next grant only after the response handshake.
5. Assert rst in EXEC after accepting op=000, A=0x01, B=0x02. Required: no rsp_valid; flags=0; op_count=0; state IDLE; next request served normally, with requester 0 winning a tie.
6. Opcodes 101, 110 and 111 with A=0x0F, B=0xF0. Required: results 0xF0 {n1}, 0x0F {n0}, 0x00 {z1}; c=v=0; the flags register tracks each completed op. Force op_count to wrap with CntWidth=2: 4 ops give op_count=0.
